mac_wb_buffer: RTL and testbench



---
 rtl/mac_wb_pkg.sv | 18 +
 rtl/mac_wb_fifo.sv | 54 +++++
 rtl/mac_wb_buffer.sv | 120 ++++++++++++
 tb/tb_mac_wb_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_wb_pkg.sv
// Shared types and default sizes for the MAC writeback buffer.
// Optional feature macro: MAC_WB_BYPASS_EN (zero-latency bypass when the FIFO is empty).
package mac_wb_pkg;

    localparam int DEF_DEPTH         = 4;
    localparam int DEF_XLEN          = 32;
    localparam int DEF_TRANS_ID_BITS = 4;

    // One extra MSB so full and empty can be told apart when the indices match
    localparam int PTR_W = $clog2(DEF_DEPTH) + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [DEF_XLEN-1:0]          result;
        logic [DEF_TRANS_ID_BITS-1:0] trans_id;
    } wb_entry_t;

endpackage

// File: rtl/mac_wb_fifo.sv
// Generic synchronous FIFO of writeback entries.
// Pointers carry one wrap bit; full/empty come from the MSB difference.
// Push and pop in the same cycle are legal even when full (the caller
// guarantees it never pushes into a full FIFO without also popping).
module mac_wb_fifo
    import mac_wb_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; clear rewinds both so the FIFO reads as empty
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage; zeroed on reset so the idle head reads as zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mac_wb_buffer.sv
// Consumer end of the MAC functional unit: credit-gated issue, result FIFO,
// and valid/ready writeback to the scoreboard.
// Optional feature macro: MAC_WB_BYPASS_EN -- when the FIFO is empty an
// arriving result is presented on the writeback port in the same cycle.
module mac_wb_buffer
    import mac_wb_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int XLEN          = DEF_XLEN,
    parameter int TRANS_ID_BITS = DEF_TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic                     fu_valid_i,
    input  logic [XLEN-1:0]          fu_result_i,
    input  logic [TRANS_ID_BITS-1:0] fu_trans_id_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     error_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int DEPTH_I = DEPTH;
    localparam logic [AW+1:0] DEPTH_L = DEPTH_I[AW+1:0];

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    entry_t      fu_entry;
    entry_t      head;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic [AW:0] inflight;
    logic [AW+1:0] used;

    logic fire;
    logic fu_in;
    logic unexpected;
    logic overflow;
    logic push_ok;
    logic head_valid;
    logic pop_head;
    logic bypass;
    logic fifo_push;

    // Credits: slots not already claimed by buffered or in-flight results.
    // Only registered state feeds this, so wb_ready_i has no path to it and
    // a popped slot is returned the following cycle.
    assign used          = {1'b0, count} + {1'b0, inflight};
    assign issue_ready_o = (used < DEPTH_L) & ~flush_i & ~rst_i;
    assign fire          = issue_valid_i & issue_ready_o;

    // Result acceptance; protocol violations are dropped and flagged
    assign fu_in      = fu_valid_i & ~flush_i;
    assign head_valid = ~empty & ~flush_i;
    assign pop_head   = head_valid & wb_ready_i;
    assign unexpected = fu_in & (inflight == '0);
    assign overflow   = fu_in & full & ~pop_head;
    assign push_ok    = fu_in & ~unexpected & ~overflow;

`ifdef MAC_WB_BYPASS_EN
    // Overflow cannot occur while empty, so it is left out to keep the
    // writeback valid free of any loop through the pop term
    assign bypass = empty & fu_in & (inflight != '0);
`else
    assign bypass = 1'b0;
`endif

    assign fu_entry  = {fu_result_i, fu_trans_id_i};
    assign fifo_push = push_ok & ~(bypass & wb_ready_i);

    assign wb_valid_o    = head_valid | bypass;
    assign wb_result_o   = bypass ? fu_result_i   : head.result;
    assign wb_trans_id_o = bypass ? fu_trans_id_i : head.trans_id;

    mac_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (flush_i),
        .push   (fifo_push),
        .pop    (pop_head),
        .din    (fu_entry),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // In-flight ops: +1 on issue, -1 on an accepted result; flush kills all
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            inflight <= '0;
        end else if (fire && !push_ok) begin
            inflight <= inflight + 1'b1;
        end else if (!fire && push_ok) begin
            inflight <= inflight - 1'b1;
        end
    end

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_o <= 1'b0;
        end else if (unexpected || overflow) begin
            error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_wb_buffer.sv
// Self-checking bench for mac_wb_buffer: directed test-plan steps followed by
// randomized traffic through a 3-stage MAC delay model, all checked against a
// queue-based reference of the buffer behaviour.
module tb_mac_wb_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, fu_valid, wb_ready;
    logic [31:0] fu_result;
    logic [3:0]  fu_tid;
    logic        issue_ready, wb_valid, error;
    logic [31:0] wb_result;
    logic [3:0]  wb_tid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [31:0] r; logic [3:0] id; } ent_t;
    ent_t q[$];
    int   inflight = 0;
    bit   err = 0;
    bit   last_fire;

    // MAC pipeline model for the random phase
    bit          pv  [3];
    logic [31:0] pr  [3];
    logic [3:0]  pid [3];

    always #5 clk = ~clk;

    mac_wb_buffer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .fu_valid_i    (fu_valid),
        .fu_result_i   (fu_result),
        .fu_trans_id_i (fu_tid),
        .wb_valid_o    (wb_valid),
        .wb_ready_i    (wb_ready),
        .wb_result_o   (wb_result),
        .wb_trans_id_o (wb_tid),
        .error_o       (error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit iv, input bit fv, input logic [31:0] res,
                         input logic [3:0] id, input bit wr, input bit fl);
        issue_valid = iv; fu_valid = fv; fu_result = res; fu_tid = id;
        wb_ready = wr; flush = fl;
    endtask

    // Check outputs against the reference, then advance reference and clock
    task automatic step();
        bit er, ev, pop, acc, byp;
        #1;
        er  = !rst && !flush && (q.size() + inflight < DEPTH);
        ev  = !rst && !flush && q.size() > 0;
        byp = 1'b0;
`ifdef MAC_WB_BYPASS_EN
        if (!rst && !flush && q.size() == 0 && fu_valid && inflight > 0) begin
            ev = 1'b1; byp = 1'b1;
        end
`endif
        chk("issue_ready", issue_ready, er);
        if (!rst) begin
            chk("wb_valid", wb_valid, ev);
            chk("error", error, err);
            if (ev) begin
                chk("wb_result", wb_result, byp ? fu_result : q[0].r);
                chk("wb_trans_id", wb_tid, byp ? fu_tid : q[0].id);
            end
        end
        last_fire = issue_valid && er;
        if (rst) begin
            q.delete(); inflight = 0; err = 1'b0;
        end else if (flush) begin
            q.delete(); inflight = 0;
        end else begin
            pop = ev && wb_ready;
            acc = 1'b0;
            if (fu_valid) begin
                if (inflight == 0)                   err = 1'b1;
                else if (q.size() == DEPTH && !pop)  err = 1'b1;
                else                                 acc = 1'b1;
            end
            if (pop && !byp) void'(q.pop_front());
            if (acc && !(byp && wb_ready)) q.push_back('{fu_result, fu_tid});
            inflight += int'(last_fire) - int'(acc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, '0, '0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        step(); step();
        rst = 1'b0;

        // Reset state and idle
        #1;
        chk("rst_ready", issue_ready, 1'b1);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_result", wb_result, 32'h0);
        chk("rst_tid", wb_tid, 4'h0);
        chk("rst_error", error, 1'b0);
        step();

        // Four issues with no returns exhaust the credits
        for (int i = 0; i < 4; i++) begin drive(1, 0, '0, '0, 0, 0); step(); end
        drive(0, 0, '0, '0, 0, 0);
        #1 chk("t1_no_credit", issue_ready, 1'b0);
        drive(0, 0, '0, '0, 0, 1); step();
        drive(0, 0, '0, '0, 0, 0); step();

        // Single op round trip, 1-cycle writeback latency
        drive(1, 0, '0, '0, 1, 0); step();
        drive(0, 0, '0, '0, 1, 0); step(); step();
        drive(0, 1, 32'hFFFF_FF00, 4'h3, 1, 0); step();
        drive(0, 0, '0, '0, 1, 0);
        #1;
        chk("t2_valid", wb_valid, 1'b1);
        chk("t2_result", wb_result, 32'hFFFF_FF00);
        chk("t2_tid", wb_tid, 4'h3);
        step();
        #1 chk("t2_credit", issue_ready, 1'b1);

        // Fill with ready low, head stable, then drain in order
        for (int i = 0; i < 4; i++) begin drive(1, 0, '0, '0, 0, 0); step(); end
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 32'h1000 + 32'(i), 4'(i), 0, 0); step();
        end
        drive(0, 0, '0, '0, 0, 0);
        #1;
        chk("t3_full_ready", issue_ready, 1'b0);
        chk("t3_head", wb_tid, 4'h1);
        step();
        chk("t3_head_stable", wb_tid, 4'h1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, '0, '0, 1, 0);
            #1 chk("t3_drain", wb_tid, 4'(i));
            step();
        end
        drive(0, 0, '0, '0, 0, 0); step();

        // Flush with buffered and in-flight ops plus a result in the flush cycle
        for (int i = 0; i < 4; i++) begin drive(1, 0, '0, '0, 0, 0); step(); end
        drive(0, 1, 32'h55, 4'h5, 0, 0); step();
        drive(0, 1, 32'h66, 4'h6, 0, 0); step();
        drive(1, 1, 32'h77, 4'h7, 1, 1);
        #1 chk("t4_flush_valid", wb_valid, 1'b0);
        step();
        drive(0, 0, '0, '0, 0, 0);
        #1;
        chk("t4_ready", issue_ready, 1'b1);
        chk("t4_error", error, 1'b0);
        for (int i = 0; i < 4; i++) begin drive(1, 0, '0, '0, 0, 0); step(); end
        drive(0, 0, '0, '0, 0, 1); step();

        // Unexpected result sets a sticky error, cleared only by reset
        drive(0, 1, 32'hDEAD, 4'h9, 1, 0); step();
        drive(0, 0, '0, '0, 1, 0);
        #1;
        chk("t5_error", error, 1'b1);
        chk("t5_empty", wb_valid, 1'b0);
        step(); step(); step();
        chk("t5_sticky", error, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        #1 chk("t5_cleared", error, 1'b0);

        // Random traffic through a 3-stage MAC model
        for (int k = 0; k < 3; k++) pv[k] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            drive(bit'($urandom_range(0, 1)), pv[2], pr[2], pid[2],
                  $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
            step();
            if (flush) begin
                for (int k = 0; k < 3; k++) pv[k] = 1'b0;
            end else begin
                pv[2] = pv[1]; pr[2] = pr[1]; pid[2] = pid[1];
                pv[1] = pv[0]; pr[1] = pr[0]; pid[1] = pid[0];
                pv[0] = last_fire; pr[0] = $urandom; pid[0] = 4'($urandom);
            end
        end
        drive(0, 0, '0, '0, 1, 0);
        for (int c = 0; c < 8; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
